edge_pixel_fetch: RTL and testbench



---
 rtl/edge_fetch_pkg.sv | 31 +++
 rtl/edge_pixel_addr.sv | 33 +++
 rtl/edge_pixel_fetch.sv | 162 ++++++++++++++++
 tb/tb_edge_pixel_fetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_fetch_pkg.sv
// Shared types and constants for the edge-detection pixel fetch path.
// The helper functions pick one pixel lane out of a memory word and bump the saturating miss counter.
package edge_fetch_pkg;

  localparam int PIXEL_W      = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 4;
  localparam int COORD_W      = 11;
  localparam int LANE_W       = $clog2(PIX_PER_WORD);
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } fetch_state_t;

  function automatic logic [PIXEL_W-1:0] lane_select(input logic [WORD_W-1:0] word,
                                                      input logic [LANE_W-1:0] lane);
    lane_select = word[PIXEL_W*lane +: PIXEL_W];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/edge_pixel_addr.sv
// Coordinate decode: signed (x,y) to frame range flag, word-aligned byte address and byte lane.
module edge_pixel_addr
  import edge_fetch_pkg::*;
#(
  parameter int                COL_NUM   = 640,
  parameter int                ROW_NUM   = 480,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               in_range,
  output logic [ADDR_W-1:0]  word_addr,
  output logic [LANE_W-1:0]  lane
);

  logic [ADDR_W-1:0] w_x_ext;
  logic [ADDR_W-1:0] w_y_ext;
  logic [ADDR_W-1:0] w_byte_addr;

  // Sign-extend so negative coordinates wrap naturally in the address arithmetic.
  assign w_x_ext = {{(ADDR_W-COORD_W){req_x[COORD_W-1]}}, req_x};
  assign w_y_ext = {{(ADDR_W-COORD_W){req_y[COORD_W-1]}}, req_y};

  assign w_byte_addr = BASE_ADDR + (w_y_ext * ADDR_W'(COL_NUM)) + w_x_ext;

  assign in_range = !req_x[COORD_W-1] && !req_y[COORD_W-1] &&
                    (req_x < COORD_W'(COL_NUM)) && (req_y < COORD_W'(ROW_NUM));

  assign word_addr = {w_byte_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign lane      = w_byte_addr[LANE_W-1:0];

endmodule

// File: rtl/edge_pixel_fetch.sv
// Pixel responder with a one-word cache; misses are filled through an Avalon-MM read master.
// Only one read is ever outstanding; a flush during a fill marks the returning word for discard.
module edge_pixel_fetch
  import edge_fetch_pkg::*;
#(
  parameter int                COL_NUM   = 640,
  parameter int                ROW_NUM   = 480,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                flush,
  input  logic [COORD_W-1:0]  req_x,
  input  logic [COORD_W-1:0]  req_y,
  output logic                waitrequest,
  output logic [PIXEL_W-1:0]  pixel,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  input  logic                m_waitrequest,
  input  logic [WORD_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [CNT_W-1:0]    miss_count
);

  fetch_state_t       r_state;
  logic               r_valid;
  logic [ADDR_W-1:0]  r_tag;
  logic [WORD_W-1:0]  r_data;
  logic               r_discard;
  logic [ADDR_W-1:0]  r_m_address;
  logic [CNT_W-1:0]   r_miss_count;

  fetch_state_t       w_state_nxt;
  logic               w_valid_nxt;
  logic [ADDR_W-1:0]  w_tag_nxt;
  logic [WORD_W-1:0]  w_data_nxt;
  logic               w_discard_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [CNT_W-1:0]   w_count_nxt;

  logic               w_in_range;
  logic [ADDR_W-1:0]  w_word_addr;
  logic [LANE_W-1:0]  w_lane;
  logic               w_hit;

  edge_pixel_addr #(
    .COL_NUM   (COL_NUM),
    .ROW_NUM   (ROW_NUM),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr (
    .req_x     (req_x),
    .req_y     (req_y),
    .in_range  (w_in_range),
    .word_addr (w_word_addr),
    .lane      (w_lane)
  );

  assign w_hit = r_valid && (r_tag == w_word_addr);

  // Requester-side response: a hit is answered in the same cycle.
  always_comb begin
    waitrequest = 1'b1;
    pixel       = {PIXEL_W{1'b0}};
    if (!rst_n) begin
      waitrequest = 1'b1;
    end else if (!en || !w_in_range) begin
      waitrequest = 1'b0;
    end else if (w_hit) begin
      waitrequest = 1'b0;
      pixel       = lane_select(r_data, w_lane);
    end else begin
      waitrequest = 1'b1;
    end
  end

  // Next-state, cache fill and flush handling.
  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_tag_nxt     = r_tag;
    w_data_nxt    = r_data;
    w_discard_nxt = r_discard;
    w_addr_nxt    = r_m_address;
    w_count_nxt   = r_miss_count;
    case (r_state)
      IDLE: begin
        if (en && w_in_range && !w_hit) begin
          w_addr_nxt  = w_word_addr;
          w_count_nxt = sat_inc(r_miss_count);
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          w_state_nxt = WAIT_DATA;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      WAIT_DATA: begin
        if (m_readdatavalid) begin
          if (!r_discard) begin
            w_valid_nxt = 1'b1;
            w_tag_nxt   = r_m_address;
            w_data_nxt  = m_readdata;
          end else begin
            w_valid_nxt = r_valid;
          end
          w_discard_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else begin
          w_state_nxt = WAIT_DATA;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Flush overrides any fill; a read still in flight must not be cached when it lands.
    if (flush) begin
      w_valid_nxt = 1'b0;
      if ((r_state == ISSUE) || ((r_state == WAIT_DATA) && !m_readdatavalid)) begin
        w_discard_nxt = 1'b1;
      end else begin
        w_discard_nxt = 1'b0;
      end
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
  end

  // State, cache and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_tag        <= {ADDR_W{1'b0}};
      r_data       <= {WORD_W{1'b0}};
      r_discard    <= 1'b0;
      r_m_address  <= {ADDR_W{1'b0}};
      r_miss_count <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_valid      <= w_valid_nxt;
      r_tag        <= w_tag_nxt;
      r_data       <= w_data_nxt;
      r_discard    <= w_discard_nxt;
      r_m_address  <= w_addr_nxt;
      r_miss_count <= w_count_nxt;
    end
  end

  assign m_read     = (r_state == ISSUE);
  assign m_address  = r_m_address;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_edge_pixel_fetch.sv
// Directed bench for edge_pixel_fetch: a bus-level memory responder, a cache-level reference
// model compared every cycle, and hand-computed expectations for each scenario.
module tb_edge_pixel_fetch;

  localparam int          COL  = 640;
  localparam int          ROW  = 480;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n, en, flush;
  logic [10:0] req_x, req_y;
  logic        waitrequest;
  logic [7:0]  pixel;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  edge_pixel_fetch #(
    .COL_NUM(COL), .ROW_NUM(ROW), .ADDR_W(32), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .req_x(req_x), .req_y(req_y),
    .waitrequest(waitrequest), .pixel(pixel),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'h5A;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic in_rng(input logic [10:0] x, input logic [10:0] y);
    int xi, yi;
    xi = $signed(x);
    yi = $signed(y);
    return (xi >= 0) && (yi >= 0) && (xi < COL) && (yi < ROW);
  endfunction

  function automatic logic [31:0] byte_addr(input logic [10:0] x, input logic [10:0] y);
    int xi, yi;
    xi = $signed(x);
    yi = $signed(y);
    return BASE + 32'(yi * COL + xi);
  endfunction

  logic        mv, mbusy, mdisc;
  logic [31:0] mtag, mdata, mpend;
  logic [15:0] mcnt;

  function automatic logic mdl_hit();
    return mv && (mtag == (byte_addr(req_x, req_y) & 32'hFFFF_FFFC));
  endfunction

  function automatic logic mdl_wait();
    if (!en || !in_rng(req_x, req_y)) return 1'b0;
    return !mdl_hit();
  endfunction

  function automatic logic [7:0] mdl_pix();
    logic [31:0] sh;
    if (!en || !in_rng(req_x, req_y) || !mdl_hit()) return 8'h00;
    sh = mdata >> (8 * byte_addr(req_x, req_y)[1:0]);
    return sh[7:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 1'b0; mbusy <= 1'b0; mdisc <= 1'b0;
      mtag <= 32'd0; mdata <= 32'd0; mpend <= 32'd0; mcnt <= 16'd0;
    end else begin
      if (mbusy && m_readdatavalid) begin
        if (!mdisc) begin
          mv <= 1'b1; mtag <= mpend; mdata <= m_readdata;
        end
        mbusy <= 1'b0;
        mdisc <= 1'b0;
      end else if (!mbusy && en && in_rng(req_x, req_y) && !mdl_hit()) begin
        mbusy <= 1'b1;
        mpend <= byte_addr(req_x, req_y) & 32'hFFFF_FFFC;
        mcnt  <= (mcnt == 16'hFFFF) ? mcnt : mcnt + 16'd1;
      end
      if (flush) begin
        mv <= 1'b0;
        if (mbusy && !m_readdatavalid) mdisc <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("mdl_waitrequest", waitrequest, mdl_wait());
      chk("mdl_pixel", pixel, mdl_pix());
      chk("mdl_miss_count", miss_count, mcnt);
      if (!mbusy) chk("mdl_no_read_when_idle", m_read, 1'b0);
      if (m_read) chk("mdl_read_address", m_address, mpend);
    end
  end

  // ---------------- memory responder ----------------
  int          stall_cfg = 0, lat_cfg = 1, phase = 0, stall_left = 0, lat_left = 0;
  int          rdv_cyc = -100;
  logic [31:0] acc_addr = 32'd0;
  logic        use_ovr = 1'b0;
  logic [31:0] ovr_data = 32'd0;

  initial begin
    m_waitrequest = 1'b1;
    m_readdatavalid = 1'b0;
    m_readdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      m_readdatavalid = 1'b0;
      if (!rst_n) begin
        phase = 0;
        m_waitrequest = 1'b1;
      end else begin
        if (phase == 0 && m_read) begin
          stall_left = stall_cfg;
          phase = 1;
        end
        if (phase == 1) begin
          if (stall_left == 0) begin
            m_waitrequest = 1'b0;
            acc_addr = m_address;
            phase = 2;
          end else begin
            stall_left--;
            m_waitrequest = 1'b1;
          end
        end else if (phase == 2) begin
          m_waitrequest = 1'b1;
          lat_left = lat_cfg - 1;
          phase = 3;
        end
        if (phase == 3) begin
          if (lat_left == 0) begin
            m_readdatavalid = 1'b1;
            m_readdata = use_ovr ? ovr_data : mem_word(acc_addr);
            use_ovr = 1'b0;
            rdv_cyc = cyc;
            phase = 0;
          end else begin
            lat_left--;
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name, input int maxc);
    int got;
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      @(negedge clk);
      if (!waitrequest) begin
        got = 1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  int          oob_x[3];
  int          oob_y[3];
  int          rd_cycles, ready_cyc;
  logic [31:0] w5;

  initial begin
    oob_x = '{-1, 640, 0};
    oob_y = '{5, 0, 480};
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; req_x = 11'd0; req_y = 11'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_waitrequest", waitrequest, 1'b1);
    chk("reset_pixel", pixel, 8'h00);
    chk("reset_m_read", m_read, 1'b0);
    chk("reset_m_address", m_address, 32'd0);
    chk("reset_miss_count", miss_count, 16'd0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // Basic miss at (0,0), one-cycle data latency.
    ovr_data = 32'h4433_2211; use_ovr = 1'b1;
    en = 1'b1; req_x = 11'd0; req_y = 11'd0;
    @(negedge clk); chk("t1_c0_wait", waitrequest, 1'b1);
    step(); @(negedge clk);
    chk("t1_c1_wait", waitrequest, 1'b1);
    chk("t1_c1_read", m_read, 1'b1);
    chk("t1_c1_addr", m_address, 32'h0000_1000);
    step(); @(negedge clk); chk("t1_c2_wait", waitrequest, 1'b1);
    step(); @(negedge clk);
    chk("t1_c3_wait", waitrequest, 1'b0);
    chk("t1_c3_pixel", pixel, 8'h11);
    chk("t1_c3_count", miss_count, 16'd1);

    // Hits on the remaining lanes, then the next word misses.
    for (int x = 1; x < 4; x++) begin
      step(); req_x = 11'(x);
      @(negedge clk);
      chk("t2_hit_wait", waitrequest, 1'b0);
      chk("t2_hit_pixel", pixel, 8'(8'h11 * (x + 1)));
      chk("t2_hit_no_read", m_read, 1'b0);
    end
    step(); req_x = 11'd4;
    @(negedge clk); chk("t2_x4_wait", waitrequest, 1'b1);
    step(); @(negedge clk);
    chk("t2_x4_addr", m_address, 32'h0000_1004);
    chk("t2_x4_count", miss_count, 16'd2);
    wait_ready("t2_x4_fill_timeout", 20);

    // Out-of-frame padding coordinates.
    for (int i = 0; i < 3; i++) begin
      step(); req_x = 11'(oob_x[i]); req_y = 11'(oob_y[i]);
      @(negedge clk);
      chk("t3_oob_wait", waitrequest, 1'b0);
      chk("t3_oob_pixel", pixel, 8'h00);
      chk("t3_oob_no_read", m_read, 1'b0);
    end

    // Interconnect stall of 5 cycles, data 3 cycles after accept.
    stall_cfg = 5; lat_cfg = 3;
    step(); req_x = 11'd8; req_y = 11'd0;
    rd_cycles = 0; ready_cyc = -1;
    for (int i = 0; i < 40 && ready_cyc < 0; i++) begin
      @(negedge clk);
      if (m_read) begin
        rd_cycles++;
        chk("t4_addr_stable", m_address, 32'h0000_1008);
      end
      if (!waitrequest) ready_cyc = cyc;
      else step();
    end
    chk("t4_read_cycles", rd_cycles, 6);
    chk("t4_ready_after_rdv", ready_cyc, rdv_cyc + 1);

    // Flush while waiting for data: the returning word is dropped and re-fetched.
    stall_cfg = 0; lat_cfg = 2;
    step(); req_x = 11'd12;
    ovr_data = 32'hAABB_CCDD; use_ovr = 1'b1;
    @(negedge clk); chk("t5_c0_wait", waitrequest, 1'b1);
    step(); step(); flush = 1'b1;
    @(negedge clk); chk("t5_c2_wait", waitrequest, 1'b1);
    step(); flush = 1'b0;
    @(negedge clk); chk("t5_c3_wait", waitrequest, 1'b1);
    step(); @(negedge clk); chk("t5_remiss_wait", waitrequest, 1'b1);
    wait_ready("t5_refill_timeout", 20);
    w5 = mem_word(32'h0000_100C);
    chk("t5_count", miss_count, 16'd5);
    chk("t5_pixel_refetched", pixel, w5[7:0]);

    // Bottom-right corner pixel.
    lat_cfg = 1;
    step(); req_x = 11'd639; req_y = 11'd479;
    ovr_data = 32'h1122_3344; use_ovr = 1'b1;
    @(negedge clk); chk("t6_c0_wait", waitrequest, 1'b1);
    step(); @(negedge clk); chk("t6_addr", m_address, 32'h0004_BFFC);
    wait_ready("t6_fill_timeout", 20);
    chk("t6_pixel_lane3", pixel, 8'h11);

    // en dropped mid-miss: fill still lands in the cache.
    step(); req_x = 11'd0; req_y = 11'd1;
    @(negedge clk); chk("t7_c0_wait", waitrequest, 1'b1);
    step(); en = 1'b0;
    @(negedge clk);
    chk("t7_disabled_wait", waitrequest, 1'b0);
    chk("t7_disabled_pixel", pixel, 8'h00);
    repeat (3) step();
    en = 1'b1;
    @(negedge clk);
    chk("t7_filled_hit", waitrequest, 1'b0);
    chk("final_count", miss_count, 16'd7);

    step();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
